// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [1:0] CLASS_MODIFIER = 2'b10;
  localparam logic [1:0] CLASS_ESCAPED  = 2'b11;

  localparam logic [7:0] ESC        = 8'h1B;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         PS2_BITS   = 11;

endpackage

// File: rtl/keymap_rom.sv
// Keymap ROM: address {ext, caps_lock, shift, scancode}, registered output.
// Bits 7:6 of each entry give the class; modifier entries carry a bit mask.
module keymap_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  q
);

  logic       ext;
  logic       upper;
  logic [7:0] code;
  logic [7:0] value;

  assign ext   = addr[10];
  assign upper = addr[9] ^ addr[8];
  assign code  = addr[7:0];

  function automatic logic [7:0] letter(input logic [7:0] lower, input logic up);
    return up ? (lower - 8'h20) : lower;
  endfunction

  always_comb begin
    value = 8'h00;
    case ({ext, code})
      9'h01C: value = letter(8'h61, upper);
      9'h032: value = letter(8'h62, upper);
      9'h021: value = letter(8'h63, upper);
      9'h023: value = letter(8'h64, upper);
      9'h024: value = letter(8'h65, upper);
      9'h016: value = addr[8] ? 8'h21 : 8'h31;
      9'h029: value = 8'h20;
      9'h05A: value = 8'h0D;
      9'h066: value = 8'h08;
      9'h076: value = 8'h1B;
      9'h012: value = 8'h81;
      9'h014: value = 8'h82;
      9'h011: value = 8'h84;
      9'h111: value = 8'h88;
      9'h114: value = 8'h90;
      9'h059: value = 8'hA0;
      9'h058: value = 8'h80;
      9'h175: value = 8'hC1;
      9'h172: value = 8'hC2;
      9'h174: value = 8'hC3;
      9'h16B: value = 8'hC4;
      default: value = 8'h00;
    endcase
  end

  always_ff @(posedge clk) q <= value;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: pin synchronisers, clock glitch filter, 11-bit framing
// with odd parity, and a mid-frame idle timeout.
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic [TW-1:0] idle_cnt;

  logic [10:0] frame;
  logic        last_bit;
  logic        frame_ok;
  logic        timeout;

  assign frame    = {data_sync[1], shreg[10:1]};
  assign last_bit = (bit_cnt == 4'(PS2_BITS - 1));
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  assign timeout  = (bit_cnt != 4'd0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      filt        <= 1'b1;
      filt_cnt    <= '0;
      fall        <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      idle_cnt    <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= '0;
      frame_error <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk};
      data_sync   <= {data_sync[0], ps2_data};
      fall        <= 1'b0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;

      // Level flips on the FILTER_LEN-th consecutive differing sample.
      if (clk_sync[1] != filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt     <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= filt;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end

      if (fall) begin
        idle_cnt <= '0;
        shreg    <= frame;
        if (last_bit) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= frame[8:1];
          end else begin
            frame_error <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (timeout) begin
        bit_cnt     <= '0;
        idle_cnt    <= '0;
        frame_error <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard front end: prefix decode, modifier/caps tracking, keymap
// lookup and a first-word fall-through output FIFO. Define
// PS2_TYPEMATIC_FILTER_EN to suppress auto-repeated makes of the same key.
module ps2_keyboard_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    data,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  output logic                          caps_lock,
  output logic [5:0]                    modifiers
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic       rx_valid;
  logic       rx_error;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_valid  (rx_valid),
    .rx_byte     (rx_byte),
    .frame_error (rx_error)
  );

  assign frame_error = rx_error;

  state_t      state;
  state_t      state_nxt;
  logic        ext;
  logic        brk;
  logic [7:0]  cur_byte;
  logic [7:0]  rom_q;
  logic        shift;
  logic        control;
  logic        meta;
  logic        repeat_hit;

  assign shift   = modifiers[5] | modifiers[0];
  assign control = modifiers[4] | modifiers[1];
  assign meta    = modifiers[3] | modifiers[2];

  keymap_rom u_rom (
    .clk  (clk),
    .addr ({ext, caps_lock, shift, cur_byte}),
    .q    (rom_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_valid && rx_byte != PREFIX_EXT && rx_byte != PREFIX_BRK) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = DECODE;
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      cur_byte <= '0;
    end else if (rx_error || state == DECODE) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (state == IDLE && rx_valid) begin
      if (rx_byte == PREFIX_EXT)      ext      <= 1'b1;
      else if (rx_byte == PREFIX_BRK) brk      <= 1'b1;
      else                            cur_byte <= rx_byte;
    end
  end

  logic [1:0] need;
  logic [7:0] b0;
  logic [7:0] b1;
  logic [5:0] mods_set;
  logic [5:0] mods_clr;
  logic       caps_tgl;

  // Event resolution in DECODE: a make yields 0, 1 or 2 bytes to push.
  always_comb begin
    need     = 2'd0;
    b0       = 8'h00;
    b1       = 8'h00;
    mods_set = '0;
    mods_clr = '0;
    caps_tgl = 1'b0;
    if (state == DECODE && rom_q != 8'h00) begin
      if (brk) begin
        if (rom_q[7:6] == CLASS_MODIFIER) mods_clr = rom_q[5:0];
      end else if (rom_q[7:6] == CLASS_MODIFIER) begin
        if (rom_q[5:0] == 6'd0) caps_tgl = 1'b1;
        else                    mods_set = rom_q[5:0];
      end else if (!repeat_hit) begin
        if (rom_q[7:6] == CLASS_ESCAPED || meta) begin
          need = 2'd2;
          b0   = ESC;
          b1   = {1'b0, control ? 2'b00 : rom_q[6:5], rom_q[4:0]};
        end else if (control) begin
          need = 2'd1;
          b0   = {3'b000, rom_q[4:0]};
        end else begin
          need = 2'd1;
          b0   = rom_q;
        end
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_key;
  logic       last_valid;

  assign repeat_hit = last_valid && (last_key == {ext, cur_byte});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_key   <= '0;
      last_valid <= 1'b0;
    end else if (state == DECODE) begin
      if (brk) begin
        if (repeat_hit) last_valid <= 1'b0;
      end else if (rom_q != 8'h00 && rom_q[7:6] != CLASS_MODIFIER) begin
        last_valid <= 1'b1;
        last_key   <= {ext, cur_byte};
      end
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      modifiers <= '0;
      caps_lock <= 1'b0;
    end else begin
      modifiers <= (modifiers | mods_set) & ~mods_clr;
      caps_lock <= caps_lock ^ caps_tgl;
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] free;
  logic          fits;
  logic [1:0]    push_cnt;
  logic          pop;

  // Space is judged on the pre-pop level so an event never relies on a same-cycle pop.
  assign free     = LW'(FIFO_DEPTH) - fifo_level;
  assign fits     = (LW'(need) <= free);
  assign push_cnt = fits ? need : 2'd0;
  assign valid    = (fifo_level != '0);
  assign pop      = valid && ready;
  assign data     = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= b0;
    if (push_cnt == 2'd2) mem[wr_ptr + 1'b1] <= b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push_cnt);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + LW'(push_cnt) - LW'(pop);
      overflow   <= (need != 2'd0) && !fits;
    end
  end

endmodule
